serv_mac_seq: RTL and testbench

SERV_MAC_SEQ -- requirements
Module: serv_mac_seq

---
 rtl/serv_mac_pkg.sv | 18 +
 rtl/serv_mac_seq_if.sv | 32 +++
 rtl/serv_mac_iter_cnt.sv | 42 ++++
 rtl/serv_mac_seq.sv | 95 +++++++++
 tb/tb_serv_mac_seq.sv | 276 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/serv_mac_pkg.sv
// Shared types and constants for the SERV MAC iteration sequencer.
// Holds the FSM state encoding and the default iteration count.
package serv_mac_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    STEP1 = 2'd1,
    STEP2 = 2'd2,
    DONE  = 2'd3
  } mac_state_e;

  localparam int MAC_ITER_DEF = 32;

  function automatic int iter_w(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/serv_mac_seq_if.sv
// Core <-> MAC sequencer bundle: pass control in, step strobes out.
// master = core/decoder side, slave = sequencer side.
interface serv_mac_seq_if #(
  parameter int IW = 6
) (
  input logic clk
);

  logic          mac_req;
  logic          init;
  logic          cnt_done;
  logic          trap;
  logic          rs1_zero;
  logic          mac_step1;
  logic          mac_step2;
  logic          busy;
  logic          done;
  logic [IW-1:0] iter;

  modport master (
    input  clk,
    output mac_req, init, cnt_done, trap, rs1_zero,
    input  mac_step1, mac_step2, busy, done, iter
  );

  modport slave (
    input  clk,
    input  mac_req, init, cnt_done, trap, rs1_zero,
    output mac_step1, mac_step2, busy, done, iter
  );

endinterface

// File: rtl/serv_mac_iter_cnt.sv
// Saturating MAC iteration counter with clear, increment and terminal count.
// The count holds at MAC_ITER-1 so it can never wrap.
module serv_mac_iter_cnt
  import serv_mac_pkg::*;
#(
  parameter int MAC_ITER = MAC_ITER_DEF,
  parameter int IW       = iter_w(MAC_ITER)
) (
  input  logic          clk,
  input  logic          i_rst_n,
  input  logic          i_clr,
  input  logic          i_inc,
  output logic [IW-1:0] o_iter,
  output logic          o_tc
);

  localparam logic [IW-1:0] LAST = IW'(MAC_ITER - 1);

  logic [IW-1:0] iter_q;
  logic [IW-1:0] iter_d;

  assign o_tc   = (iter_q == LAST);
  assign o_iter = iter_q;

  always_comb begin
    iter_d = iter_q;
    if (i_clr) begin
      iter_d = '0;
    end else if (i_inc && !o_tc) begin
      iter_d = iter_q + IW'(1);
    end
  end

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      iter_q <= '0;
    end else begin
      iter_q <= iter_d;
    end
  end

endmodule

// File: rtl/serv_mac_seq.sv
// MAC step sequencer: alternates STEP1/STEP2 passes MAC_ITER times.
// Define SERV_MAC_EARLY_EXIT_EN to finish once the multiplier is zero.
module serv_mac_seq
  import serv_mac_pkg::*;
#(
  parameter int W        = 1,
  parameter int MAC_ITER = MAC_ITER_DEF
) (
  input  logic                         clk,
  input  logic                         i_rst_n,
  input  logic                         i_mac_req,
  input  logic                         i_init,
  input  logic                         i_cnt_done,
  input  logic                         i_trap,
  input  logic                         i_rs1_zero,
  output logic                         o_mac_step1,
  output logic                         o_mac_step2,
  output logic                         o_busy,
  output logic                         o_done,
  output logic [$clog2(MAC_ITER+1)-1:0] o_iter
);

  localparam int IW = iter_w(MAC_ITER);
  localparam logic [31:0] W_BITS = 32'(W);

  mac_state_e state_q;

  logic adv;
  logic last;
  logic abort;
  logic cnt_clr;
  logic cnt_inc;
  logic cnt_tc;
  logic unused_ok;

  assign unused_ok = ^{i_rs1_zero, W_BITS[0]};

  assign adv   = i_cnt_done && !i_init;
  assign abort = i_trap && (state_q != IDLE);

`ifdef SERV_MAC_EARLY_EXIT_EN
  assign last = cnt_tc || i_rs1_zero;
`else
  assign last = cnt_tc;
`endif

  always_comb begin
    cnt_clr = 1'b0;
    cnt_inc = 1'b0;
    if (abort) begin
      cnt_clr = 1'b1;
    end else begin
      unique case (state_q)
        IDLE:    cnt_clr = 1'b1;
        STEP2:   cnt_inc = adv && !last;
        DONE:    cnt_clr = 1'b1;
        default: cnt_clr = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
    end else if (abort) begin
      state_q <= IDLE;
    end else begin
      unique case (state_q)
        IDLE:    if (i_mac_req) state_q <= STEP1;
        STEP1:   if (adv) state_q <= STEP2;
        STEP2:   if (adv) state_q <= last ? DONE : STEP1;
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  serv_mac_iter_cnt #(
    .MAC_ITER (MAC_ITER),
    .IW       (IW)
  ) u_iter_cnt (
    .clk     (clk),
    .i_rst_n (i_rst_n),
    .i_clr   (cnt_clr),
    .i_inc   (cnt_inc),
    .o_iter  (o_iter),
    .o_tc    (cnt_tc)
  );

  assign o_mac_step1 = (state_q == STEP1);
  assign o_mac_step2 = (state_q == STEP2);
  assign o_busy      = (state_q != IDLE);
  assign o_done      = (state_q == DONE);

endmodule

// File: tb/tb_serv_mac_seq.sv
// Directed bench for serv_mac_seq with MAC_ITER=4.
// Status vector = {step1, step2, busy, done, iter}.
module tb_serv_mac_seq;

  localparam int MI = 4;
  localparam int IW = $clog2(MI + 1);

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  serv_mac_seq_if #(.IW(IW)) bus (.clk(clk));

  serv_mac_seq #(
    .W        (1),
    .MAC_ITER (MI)
  ) dut (
    .clk         (clk),
    .i_rst_n     (rst_n),
    .i_mac_req   (bus.mac_req),
    .i_init      (bus.init),
    .i_cnt_done  (bus.cnt_done),
    .i_trap      (bus.trap),
    .i_rs1_zero  (bus.rs1_zero),
    .o_mac_step1 (bus.mac_step1),
    .o_mac_step2 (bus.mac_step2),
    .o_busy      (bus.busy),
    .o_done      (bus.done),
    .o_iter      (bus.iter)
  );

  int errors = 0;
  int checks = 0;
  int done_cnt = 0;

  always @(negedge clk) if (bus.done === 1'b1) done_cnt++;

  function automatic logic [3+IW:0] obs();
    return {bus.mac_step1, bus.mac_step2, bus.busy, bus.done, bus.iter};
  endfunction

  function automatic logic [3+IW:0] ex(input int s, input int it);
    logic [3:0] f;
    case (s)
      0:       f = 4'b0000;
      1:       f = 4'b1010;
      2:       f = 4'b0110;
      default: f = 4'b0011;
    endcase
    return {f, IW'(it)};
  endfunction

  task automatic cyc(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pass_(input int gap);
    cyc(gap);
    bus.cnt_done = 1'b1;
    cyc(1);
    bus.cnt_done = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.mac_req = 0; bus.init = 0; bus.cnt_done = 0;
    bus.trap = 0; bus.rs1_zero = 0;
    #2;
    if (obs() !== ex(0, 0)) begin
      errors++; $display("FAIL reset_hold: got %b want %b", obs(), ex(0, 0));
    end
    checks++;
    cyc(2);
    rst_n = 1'b1;
    cyc(2);
    if (obs() !== ex(0, 0)) begin
      errors++; $display("FAIL reset_rel: got %b want %b", obs(), ex(0, 0));
    end
    checks++;
  endtask

  task automatic test_sequence();
    int d0 = done_cnt;
    bus.mac_req = 1; cyc(); bus.mac_req = 0;
    for (int k = 0; k < MI; k++) begin
      if (obs() !== ex(1, k)) begin
        errors++; $display("FAIL seq_s1_%0d: got %b want %b", k, obs(), ex(1, k));
      end
      checks++;
      pass_(31);
      if (k < MI - 1 || 1) begin end
      if (k < MI - 1) begin
        if (obs() !== ex(2, k)) begin
          errors++; $display("FAIL seq_s2_%0d: got %b want %b", k, obs(), ex(2, k));
        end
        checks++;
      end else begin
        if (obs() !== ex(2, k)) begin
          errors++; $display("FAIL seq_s2_last: got %b want %b", obs(), ex(2, k));
        end
        checks++;
      end
      pass_(31);
    end
    if (obs() !== ex(3, MI - 1)) begin
      errors++; $display("FAIL seq_done: got %b want %b", obs(), ex(3, MI - 1));
    end
    checks++;
    cyc();
    if (obs() !== ex(0, 0)) begin
      errors++; $display("FAIL seq_idle: got %b want %b", obs(), ex(0, 0));
    end
    checks++;
    if (done_cnt !== d0 + 1) begin
      errors++; $display("FAIL seq_pulses: got %0d want %0d", done_cnt - d0, 1);
    end
    checks++;
  endtask

  task automatic test_init_ignore();
    bus.mac_req = 1; cyc(); bus.mac_req = 0;
    bus.init = 1; pass_(2); bus.init = 0;
    if (obs() !== ex(1, 0)) begin
      errors++; $display("FAIL init_hold: got %b want %b", obs(), ex(1, 0));
    end
    checks++;
    pass_(2);
    if (obs() !== ex(2, 0)) begin
      errors++; $display("FAIL init_adv: got %b want %b", obs(), ex(2, 0));
    end
    checks++;
    bus.trap = 1; cyc(); bus.trap = 0;
    if (obs() !== ex(0, 0)) begin
      errors++; $display("FAIL init_abort: got %b want %b", obs(), ex(0, 0));
    end
    checks++;
  endtask

  task automatic test_trap();
    int d0 = done_cnt;
    bus.mac_req = 1; cyc(); bus.mac_req = 0;
    repeat (5) pass_(2);
    if (obs() !== ex(2, 2)) begin
      errors++; $display("FAIL trap_pre: got %b want %b", obs(), ex(2, 2));
    end
    checks++;
    bus.trap = 1; bus.cnt_done = 1; cyc();
    bus.trap = 0; bus.cnt_done = 0;
    if (obs() !== ex(0, 0)) begin
      errors++; $display("FAIL trap_idle: got %b want %b", obs(), ex(0, 0));
    end
    checks++;
    cyc(2);
    if (done_cnt !== d0) begin
      errors++; $display("FAIL trap_nodone: got %0d want %0d", done_cnt - d0, 0);
    end
    checks++;
    bus.mac_req = 1; cyc(); bus.mac_req = 0;
    if (obs() !== ex(1, 0)) begin
      errors++; $display("FAIL trap_rereq: got %b want %b", obs(), ex(1, 0));
    end
    checks++;
    bus.trap = 1; cyc(); bus.trap = 0;
  endtask

  task automatic test_back_to_back();
    int d0 = done_cnt;
    bus.mac_req = 1; cyc();
    if (obs() !== ex(1, 0)) begin
      errors++; $display("FAIL b2b_start: got %b want %b", obs(), ex(1, 0));
    end
    checks++;
    cyc(3);
    if (obs() !== ex(1, 0)) begin
      errors++; $display("FAIL b2b_ignore: got %b want %b", obs(), ex(1, 0));
    end
    checks++;
    repeat (2 * MI) pass_(2);
    if (obs() !== ex(3, MI - 1)) begin
      errors++; $display("FAIL b2b_done: got %b want %b", obs(), ex(3, MI - 1));
    end
    checks++;
    cyc();
    if (obs() !== ex(0, 0)) begin
      errors++; $display("FAIL b2b_gap: got %b want %b", obs(), ex(0, 0));
    end
    checks++;
    cyc();
    if (obs() !== ex(1, 0)) begin
      errors++; $display("FAIL b2b_second: got %b want %b", obs(), ex(1, 0));
    end
    checks++;
    bus.mac_req = 0;
    if (done_cnt !== d0 + 1) begin
      errors++; $display("FAIL b2b_pulses: got %0d want %0d", done_cnt - d0, 1);
    end
    checks++;
    bus.trap = 1; cyc(); bus.trap = 0;
  endtask

  task automatic test_rs1_zero();
    int d0 = done_cnt;
    bus.rs1_zero = 1;
    bus.mac_req = 1; cyc(); bus.mac_req = 0;
    pass_(2); pass_(2);
`ifdef SERV_MAC_EARLY_EXIT_EN
    if (obs() !== ex(3, 0)) begin
      errors++; $display("FAIL rs1z_early: got %b want %b", obs(), ex(3, 0));
    end
    checks++;
`else
    if (obs() !== ex(1, 1)) begin
      errors++; $display("FAIL rs1z_cont: got %b want %b", obs(), ex(1, 1));
    end
    checks++;
    repeat (2 * MI - 2) pass_(2);
    if (obs() !== ex(3, MI - 1)) begin
      errors++; $display("FAIL rs1z_full: got %b want %b", obs(), ex(3, MI - 1));
    end
    checks++;
`endif
    cyc();
    bus.rs1_zero = 0;
    if (obs() !== ex(0, 0) || done_cnt !== d0 + 1) begin
      errors++;
      $display("FAIL rs1z_end: got %b/%0d want %b/1", obs(), done_cnt - d0, ex(0, 0));
    end
    checks++;
  endtask

  task automatic test_reset_mid();
    int d0 = done_cnt;
    bus.mac_req = 1; cyc(); bus.mac_req = 0;
    pass_(2);
    cyc(3);
    rst_n = 1'b0;
    #1;
    if (obs() !== ex(0, 0)) begin
      errors++; $display("FAIL rst_async: got %b want %b", obs(), ex(0, 0));
    end
    checks++;
    cyc(2);
    rst_n = 1'b1;
    cyc();
    if (obs() !== ex(0, 0) || done_cnt !== d0) begin
      errors++;
      $display("FAIL rst_after: got %b/%0d want %b/0", obs(), done_cnt - d0, ex(0, 0));
    end
    checks++;
    bus.mac_req = 1; cyc(); bus.mac_req = 0;
    if (obs() !== ex(1, 0)) begin
      errors++; $display("FAIL rst_rereq: got %b want %b", obs(), ex(1, 0));
    end
    checks++;
    repeat (2 * MI) pass_(2);
    if (obs() !== ex(3, MI - 1)) begin
      errors++; $display("FAIL rst_full: got %b want %b", obs(), ex(3, MI - 1));
    end
    checks++;
    cyc();
  endtask

  initial begin
    test_reset();
    test_sequence();
    test_init_ignore();
    test_trap();
    test_back_to_back();
    test_rs1_zero();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
